// File: rtl/armleocpu_icache_responder.sv
// armleocpu_icache_responder
//   Responder end of the fetch-side cache interface. Holds a direct-mapped,
//   one-word-per-line instruction buffer and refills misses from backing
//   instruction memory over a simple req/ack read bus.
//   Supported commands: EXECUTE (instruction fetch) and FLUSH_ALL.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   c_cmd_i         CACHE_CMD_* from fetch
//   c_address_i     fetch address, sampled together with c_cmd_i
//   c_response_o    CACHE_RESPONSE_*, registered
//   c_reset_done_o  high once the post-reset line clear has completed
//   c_load_data_o   instruction word, valid while c_response_o == DONE
//   m_req_o         bus read request, held until m_ack_i
//   m_addr_o        bus word address, stable while m_req_o
//   m_ack_i         bus completion pulse (ignored when m_req_o == 0)
//   m_err_i         bus error, qualified by m_ack_i
//   m_rdata_i       bus read data, qualified by m_ack_i
//
// Ports keep the original unsuffixed names (c_cmd, m_req, ...) so existing
// instantiations connect unchanged.
module armleocpu_icache_responder #(
  parameter int unsigned LINES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  c_cmd,
  input  logic [31:0] c_address,
  output logic [3:0]  c_response,
  output logic        c_reset_done,
  output logic [31:0] c_load_data,
  output logic        m_req,
  output logic [31:0] m_addr,
  input  logic        m_ack,
  input  logic        m_err,
  input  logic [31:0] m_rdata
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  localparam logic [3:0] CMD_NONE      = 4'd0;
  localparam logic [3:0] CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CMD_FLUSH_ALL = 4'd4;

  // PAGEFAULT (4'd4) exists in the response encoding but is never produced here.
  localparam logic [3:0] RSP_IDLE        = 4'd0;
  localparam logic [3:0] RSP_WAIT        = 4'd1;
  localparam logic [3:0] RSP_DONE        = 4'd2;
  localparam logic [3:0] RSP_ACCESSFAULT = 4'd3;
  localparam logic [3:0] RSP_MISSALIGNED = 4'd5;

  // idx carries one extra bit so FLUSH can count one step past the last line.
  localparam logic [IDX_W:0] IDX_LAST = (IDX_W + 1)'(LINES - 1);
  localparam logic [IDX_W:0] IDX_END  = (IDX_W + 1)'(LINES);
  localparam logic [IDX_W:0] IDX_ONE  = (IDX_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_READY,
    ST_REFILL,
    ST_FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W:0]    idx_q, idx_d;
  logic [3:0]        c_response_q, c_response_d;
  logic              reset_done_q, reset_done_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              m_req_q, m_req_d;
  logic [31:0]       m_addr_q, m_addr_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic [IDX_W-1:0]  c_index;
  logic [TAG_W-1:0]  c_tag;
  logic [IDX_W-1:0]  r_index;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  idx_lo;
  logic              hit;
  logic              fill_en;

  assign c_index = c_address[2+IDX_W-1:2];
  assign c_tag   = c_address[31:2+IDX_W];
  // Refill writes use the latched request address, not the live fetch address.
  assign r_index = m_addr_q[2+IDX_W-1:2];
  assign r_tag   = m_addr_q[31:2+IDX_W];
  assign idx_lo  = idx_q[IDX_W-1:0];
  assign hit     = valid_q[c_index] && (tag_q[c_index] == c_tag);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    c_response_d = c_response_q;
    reset_done_d = reset_done_q;
    load_data_d  = load_data_q;
    m_req_d      = m_req_q;
    m_addr_d     = m_addr_q;
    valid_d      = valid_q;
    fill_en      = 1'b0;

    case (state_q)
      ST_INIT: begin
        c_response_d    = RSP_IDLE;
        valid_d[idx_lo] = 1'b0;
        idx_d           = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          idx_d        = '0;
          reset_done_d = 1'b1;
          state_d      = ST_READY;
        end
      end

      ST_READY: begin
        case (c_cmd)
          CMD_NONE: c_response_d = RSP_IDLE;
          CMD_EXECUTE: begin
            if (c_address[1:0] != 2'b00) begin
              c_response_d = RSP_MISSALIGNED;
            end else if (hit) begin
              c_response_d = RSP_DONE;
              load_data_d  = data_q[c_index];
            end else begin
              c_response_d = RSP_WAIT;
              m_req_d      = 1'b1;
              m_addr_d     = {c_address[31:2], 2'b00};
              state_d      = ST_REFILL;
            end
          end
          CMD_FLUSH_ALL: begin
            idx_d        = '0;
            c_response_d = RSP_WAIT;
            state_d      = ST_FLUSH;
          end
          default: c_response_d = RSP_ACCESSFAULT;
        endcase
      end

      ST_REFILL: begin
        c_response_d = RSP_WAIT;
        if (m_ack) begin
          m_req_d = 1'b0;
          state_d = ST_READY;
          if (m_err) begin
            c_response_d = RSP_ACCESSFAULT;
          end else begin
            fill_en          = 1'b1;
            valid_d[r_index] = 1'b1;
            c_response_d     = RSP_DONE;
            load_data_d      = m_rdata;
          end
        end
      end

      ST_FLUSH: begin
        c_response_d = RSP_WAIT;
        // Clears lines 0..LINES-1, then spends one further cycle at
        // idx==LINES before reporting DONE.
        if (idx_q == IDX_END) begin
          idx_d        = '0;
          c_response_d = RSP_DONE;
          state_d      = ST_READY;
        end else begin
          valid_d[idx_lo] = 1'b0;
          idx_d           = idx_q + IDX_ONE;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      c_response_q <= RSP_IDLE;
      reset_done_q <= 1'b0;
      load_data_q  <= '0;
      m_req_q      <= 1'b0;
      m_addr_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      c_response_q <= c_response_d;
      reset_done_q <= reset_done_d;
      load_data_q  <= load_data_d;
      m_req_q      <= m_req_d;
      m_addr_q     <= m_addr_d;
    end
  end

  // Valid bits are not reset directly; INIT walks every line and clears it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && fill_en) begin
      tag_q[r_index]  <= r_tag;
      data_q[r_index] <= m_rdata;
    end
  end

  assign c_response   = c_response_q;
  assign c_reset_done = reset_done_q;
  assign c_load_data  = load_data_q;
  assign m_req        = m_req_q;
  assign m_addr       = m_addr_q;

endmodule

// File: tb/tb_armleocpu_icache_responder.sv
module tb_armleocpu_icache_responder;

  localparam int unsigned LINES = 16;

  localparam logic [3:0] CMD_NONE      = 4'd0;
  localparam logic [3:0] CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CMD_LOAD      = 4'd2;
  localparam logic [3:0] CMD_STORE     = 4'd3;
  localparam logic [3:0] CMD_FLUSH_ALL = 4'd4;

  localparam logic [3:0] RSP_IDLE        = 4'd0;
  localparam logic [3:0] RSP_WAIT        = 4'd1;
  localparam logic [3:0] RSP_DONE        = 4'd2;
  localparam logic [3:0] RSP_ACCESSFAULT = 4'd3;
  localparam logic [3:0] RSP_MISSALIGNED = 4'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  c_cmd = CMD_NONE;
  logic [31:0] c_address = '0;
  logic [3:0]  c_response;
  logic        c_reset_done;
  logic [31:0] c_load_data;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_ack = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_rdata = '0;

  armleocpu_icache_responder #(.LINES(LINES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .c_cmd        (c_cmd),
    .c_address    (c_address),
    .c_response   (c_response),
    .c_reset_done (c_reset_done),
    .c_load_data  (c_load_data),
    .m_req        (m_req),
    .m_addr       (m_addr),
    .m_ack        (m_ack),
    .m_err        (m_err),
    .m_rdata      (m_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference cache contents: line = word address mod LINES, tag = rest.
  bit          mv [LINES];
  logic [31:0] mt [LINES];
  logic [31:0] md [LINES];

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  exp_rsp;
    bit          chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endtask

  // Fetch one word; the model decides hit/miss/misaligned, and for a miss
  // the bench plays the memory, acking after 'delay' wait cycles.
  task automatic fetch(input logic [31:0] addr, input int unsigned delay,
                       input bit err, input logic [31:0] rdata, input bit scramble);
    int unsigned li;
    logic [31:0] tg;
    li = (addr / 4) % LINES;
    tg = addr / (4 * LINES);
    c_cmd = CMD_EXECUTE;
    c_address = addr;
    step();
    if (addr[1:0] != 2'b00) begin
      chk("misaligned_rsp", c_response, RSP_MISSALIGNED);
      chk("misaligned_no_req", m_req, 1'b0);
    end else if (mv[li] && mt[li] == tg) begin
      chk("hit_rsp", c_response, RSP_DONE);
      chk("hit_data", c_load_data, md[li]);
      chk("hit_no_req", m_req, 1'b0);
    end else begin
      chk("miss_rsp", c_response, RSP_WAIT);
      chk("miss_req", m_req, 1'b1);
      chk("miss_addr", m_addr, addr);
      for (int unsigned d = 0; d < delay; d++) begin
        if (scramble) begin
          c_cmd = ($urandom_range(0, 1) == 0) ? CMD_EXECUTE : CMD_FLUSH_ALL;
          c_address = $urandom & 32'hFFFF_FFFC;
        end
        step();
        chk("refill_wait_rsp", c_response, RSP_WAIT);
        chk("refill_wait_req", m_req, 1'b1);
        chk("refill_wait_addr", m_addr, addr);
      end
      m_ack = 1'b1;
      m_err = err;
      m_rdata = rdata;
      step();
      m_ack = 1'b0;
      m_err = 1'b0;
      m_rdata = $urandom;
      chk("refill_req_drop", m_req, 1'b0);
      if (err) begin
        chk("refill_err_rsp", c_response, RSP_ACCESSFAULT);
      end else begin
        chk("refill_rsp", c_response, RSP_DONE);
        chk("refill_data", c_load_data, rdata);
        mv[li] = 1'b1;
        mt[li] = tg;
        md[li] = rdata;
      end
    end
    c_cmd = CMD_NONE;
    c_address = $urandom;
  endtask

  // FLUSH_ALL accepted at edge N; WAIT through edge N+LINES, DONE after N+LINES+1.
  task automatic flush();
    c_cmd = CMD_FLUSH_ALL;
    step();
    chk("flush_accept_rsp", c_response, RSP_WAIT);
    for (int k = 1; k <= LINES; k++) begin
      if (k % 3 == 1) begin
        c_cmd = CMD_EXECUTE;
        c_address = $urandom & 32'h0000_3FFC;
      end else begin
        c_cmd = CMD_FLUSH_ALL;
      end
      step();
      chk("flush_wait_rsp", c_response, RSP_WAIT);
      chk("flush_no_req", m_req, 1'b0);
    end
    step();
    chk("flush_done_rsp", c_response, RSP_DONE);
    model_clear();
    c_cmd = CMD_NONE;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    c_cmd = CMD_NONE;
    m_ack = 1'b0;
    step();
    chk("rst_rsp", c_response, RSP_IDLE);
    chk("rst_done", c_reset_done, 1'b0);
    chk("rst_req", m_req, 1'b0);
    chk("rst_addr", m_addr, 32'h0);
    chk("rst_data", c_load_data, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= LINES; i++) begin
      step();
      chk("init_done", c_reset_done, (i == LINES) ? 1'b1 : 1'b0);
      chk("init_rsp", c_response, RSP_IDLE);
    end
    model_clear();
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Applied back-to-back once lines 0x2000/0x2004/0x2008 hold the words below.
    tbl[0]  = '{CMD_EXECUTE,   32'h2000, RSP_DONE,        1'b1, 32'h0000_0013};
    tbl[1]  = '{CMD_EXECUTE,   32'h2004, RSP_DONE,        1'b1, 32'h1111_1111};
    tbl[2]  = '{CMD_EXECUTE,   32'h2008, RSP_DONE,        1'b1, 32'h2222_2222};
    tbl[3]  = '{CMD_EXECUTE,   32'h2002, RSP_MISSALIGNED, 1'b0, 32'h0};
    tbl[4]  = '{CMD_EXECUTE,   32'h2001, RSP_MISSALIGNED, 1'b0, 32'h0};
    tbl[5]  = '{CMD_NONE,      32'h2000, RSP_IDLE,        1'b0, 32'h0};
    tbl[6]  = '{CMD_LOAD,      32'h2000, RSP_ACCESSFAULT, 1'b0, 32'h0};
    tbl[7]  = '{CMD_STORE,     32'h2004, RSP_ACCESSFAULT, 1'b0, 32'h0};
    tbl[8]  = '{4'hF,          32'h2008, RSP_ACCESSFAULT, 1'b0, 32'h0};
    tbl[9]  = '{CMD_EXECUTE,   32'h2003, RSP_MISSALIGNED, 1'b0, 32'h0};
    tbl[10] = '{CMD_EXECUTE,   32'h2004, RSP_DONE,        1'b1, 32'h1111_1111};

    do_reset();

    fetch(32'h2000, 3, 1'b0, 32'h0000_0013, 1'b0);
    fetch(32'h2000, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    fetch(32'h2002, 0, 1'b0, 32'h0, 1'b0);
    fetch(32'h4000, 1, 1'b1, 32'hBAD0_BAD0, 1'b0);
    fetch(32'h4000, 0, 1'b0, 32'hAAAA_5555, 1'b0);
    fetch(32'h2040, 2, 1'b0, 32'h4040_4040, 1'b0);
    fetch(32'h2000, 1, 1'b0, 32'h0000_0013, 1'b0);
    fetch(32'h2004, 0, 1'b0, 32'h1111_1111, 1'b0);
    fetch(32'h2008, 1, 1'b0, 32'h2222_2222, 1'b0);

    for (int i = 0; i < 11; i++) begin
      c_cmd = tbl[i].cmd;
      c_address = tbl[i].addr;
      step();
      chk($sformatf("vec%0d_rsp", i), c_response, tbl[i].exp_rsp);
      chk($sformatf("vec%0d_no_req", i), m_req, 1'b0);
      if (tbl[i].chk_data) chk($sformatf("vec%0d_data", i), c_load_data, tbl[i].exp_data);
    end
    c_cmd = CMD_NONE;

    fetch(32'h200C, 2, 1'b0, 32'h3333_3333, 1'b0);
    flush();
    fetch(32'h2000, 1, 1'b0, 32'h0000_0013, 1'b0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        flush();
      end else begin
        logic [31:0] a;
        a = 32'h1000 * $urandom_range(0, 3) + 4 * $urandom_range(0, LINES - 1);
        if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
        fetch(a, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom, 1'b1);
      end
    end

    // Reset in the middle of a refill; the late ack must be ignored.
    c_cmd = CMD_EXECUTE;
    c_address = 32'h9000_0000;
    step();
    chk("midrefill_rsp", c_response, RSP_WAIT);
    chk("midrefill_req", m_req, 1'b1);
    rst_n = 1'b0;
    c_cmd = CMD_NONE;
    step();
    chk("midrst_req", m_req, 1'b0);
    chk("midrst_rsp", c_response, RSP_IDLE);
    chk("midrst_done", c_reset_done, 1'b0);
    rst_n = 1'b1;
    m_ack = 1'b1;
    m_rdata = 32'hDEAD_0001;
    step();
    m_ack = 1'b0;
    chk("late_ack_req", m_req, 1'b0);
    chk("late_ack_rsp", c_response, RSP_IDLE);
    chk("late_ack_done", c_reset_done, 1'b0);
    for (int i = 2; i <= LINES; i++) begin
      step();
      chk("reinit_done", c_reset_done, (i == LINES) ? 1'b1 : 1'b0);
    end
    model_clear();
    fetch(32'h9000_0000, 1, 1'b0, 32'h5A5A_5A5A, 1'b0);
    fetch(32'h9000_0000, 0, 1'b0, 32'h0, 1'b0);
    fetch(32'h2000, 0, 1'b0, 32'h0000_0013, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
